// File: rtl/alu_seq_pkg.sv
// +-----------------------------------------------------------------------------
// | Module   : alu_seq_pkg
// | Brief    : Opcodes, FSM state type and opcode helpers shared by the
// |            multibyte ALU sequencer.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_supported(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_NOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_multibyte_sequencer.sv
// +-----------------------------------------------------------------------------
// | Module   : alu_multibyte_sequencer
// | Brief    : Runs one NUM_BYTES-wide operation through an external 8-bit ALU,
// |            LSB first, chaining CarryOut into CarryIn. Optional result flags
// |            are enabled by defining ALU_SEQ_FLAGS_EN.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module alu_multibyte_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [8*NUM_BYTES-1:0] req_a,
  input  logic [8*NUM_BYTES-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*NUM_BYTES-1:0] rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_error,
`ifdef ALU_SEQ_FLAGS_EN
  output logic                   rsp_zero,
  output logic                   rsp_overflow,
`endif
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic                   alu_carry_in,
  output logic [3:0]             alu_control,
  input  logic                   alu_carry_out,
  input  logic [7:0]             alu_result
);

  localparam int               c_W     = 8 * NUM_BYTES;
  localparam int               c_IDX_W = 3;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_BYTES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_op;
  logic [c_W-1:0]       r_a;
  logic [c_W-1:0]       r_b;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_W-1:0]       r_result;
  logic                 r_carry;
  logic                 r_error;
  logic                 w_arith;
  logic                 w_last;

  assign w_arith = is_arith(r_op);
  assign w_last  = (r_idx == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = is_supported(req_op) ? ISSUE : DONE;
      ISSUE:   if (w_last) w_next = DONE;
      DONE:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Non-arithmetic ops never let the ALU carry leak into the chain or response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_idx    <= '0;
          r_result <= '0;
          r_carry  <= 1'b0;
          r_error  <= !is_supported(req_op);
          if (is_supported(req_op)) begin
            r_op <= req_op;
            r_a  <= req_a;
            r_b  <= req_b;
          end
        end
        ISSUE: begin
          r_result[{r_idx, 3'b000} +: 8] <= alu_result;
          r_carry                        <= w_arith & alu_carry_out;
          r_idx                          <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_control  = 4'h0;
    alu_carry_in = 1'b0;
    if (r_state == ISSUE) begin
      alu_a        = r_a[{r_idx, 3'b000} +: 8];
      alu_b        = r_b[{r_idx, 3'b000} +: 8];
      alu_control  = r_op;
      alu_carry_in = w_arith & ((r_idx == '0) ? (r_op == OP_SUB) : r_carry);
    end
  end

  assign req_ready  = (r_state == IDLE) & rst_n;
  assign rsp_valid  = (r_state == DONE);
  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign rsp_error  = r_error;

`ifdef ALU_SEQ_FLAGS_EN
  logic r_ovf;
  logic w_ovf;

  // Sign bits come from the top byte, which is on the ALU during the last issue.
  always_comb begin
    w_ovf = 1'b0;
    if (r_op == OP_ADD)
      w_ovf = (r_a[c_W-1] == r_b[c_W-1]) && (alu_result[7] != r_a[c_W-1]);
    else if (r_op == OP_SUB)
      w_ovf = (r_a[c_W-1] != r_b[c_W-1]) && (alu_result[7] != r_a[c_W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if (r_state == IDLE && req_valid) r_ovf <= 1'b0;
    else if (r_state == ISSUE && w_last)   r_ovf <= w_ovf;
  end

  assign rsp_zero     = (r_result == '0);
  assign rsp_overflow = r_ovf;
`endif

endmodule

`default_nettype wire
